// File: rtl/linear_interpolator.sv
// Linear upsampler: each accepted signed sample produces R = 2^min(mode,4) ramp outputs ending on it.
// Optional LINTERP_PRIME_EN: the first sample after reset only seeds prev, producing no outputs.
module linear_interpolator #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic [2:0]                   mode,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         output_pulse,
    output logic                         busy
);

    // Handshake: a sample transfers on a rising edge where din_valid && din_ready;
    // din_ready is combinational and high only while enabled and IDLE.

    localparam int ACC_W  = DATA_WIDTH + 6;
    localparam int DIFF_W = DATA_WIDTH + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state_q, state_d;
    logic signed [DATA_WIDTH-1:0] prev_q, prev_d;
    logic signed [DIFF_W-1:0]    diff_q, diff_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic [4:0]                  cnt_q, cnt_d;
    logic [2:0]                  m_q, m_d;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                        pulse_q, pulse_d;

    logic [2:0]                  m_in;
    logic                        accept;
    logic                        prime_load;
    logic                        last_out;
    logic signed [DIFF_W-1:0]    diff_new;
    logic signed [ACC_W-1:0]     prev_ext, diff_new_ext, diff_q_ext, a0, a_run;

`ifdef LINTERP_PRIME_EN
    logic primed_q, primed_d;
`endif

    always_comb begin
        m_in         = (mode > 3'd4) ? 3'd4 : mode;
        din_ready    = enable && (state_q == IDLE);
        accept       = din_valid && din_ready;
        diff_new     = {din[DATA_WIDTH-1], din} - {prev_q[DATA_WIDTH-1], prev_q};
        prev_ext     = {{(ACC_W-DATA_WIDTH){prev_q[DATA_WIDTH-1]}}, prev_q};
        diff_new_ext = {{(ACC_W-DIFF_W){diff_new[DIFF_W-1]}}, diff_new};
        diff_q_ext   = {{(ACC_W-DIFF_W){diff_q[DIFF_W-1]}}, diff_q};
        // Starting the accumulator at prev*R + diff makes the first output already one step in.
        a0           = (prev_ext <<< m_in) + diff_new_ext;
        a_run        = acc_q + diff_q_ext;
        last_out     = (cnt_q == ((5'd1 << m_q) - 5'd1));
`ifdef LINTERP_PRIME_EN
        prime_load   = !primed_q;
`else
        prime_load   = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        diff_d  = diff_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        dout_d  = dout_q;
        pulse_d = 1'b0;
`ifdef LINTERP_PRIME_EN
        primed_d = primed_q;
`endif
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (prime_load) begin
                            prev_d = din;
`ifdef LINTERP_PRIME_EN
                            primed_d = 1'b1;
`endif
                        end else begin
                            diff_d  = diff_new;
                            acc_d   = a0;
                            dout_d  = DATA_WIDTH'(a0 >>> m_in);
                            pulse_d = 1'b1;
                            prev_d  = din;
                            cnt_d   = 5'd1;
                            m_d     = m_in;
                            state_d = (m_in == 3'd0) ? IDLE : RUN;
                        end
                    end
                end
                RUN: begin
                    acc_d   = a_run;
                    dout_d  = DATA_WIDTH'(a_run >>> m_q);
                    pulse_d = 1'b1;
                    cnt_d   = cnt_q + 5'd1;
                    if (last_out) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= '0;
            diff_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            dout_q  <= '0;
            pulse_q <= 1'b0;
`ifdef LINTERP_PRIME_EN
            primed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            diff_q  <= diff_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            dout_q  <= dout_d;
            pulse_q <= pulse_d;
`ifdef LINTERP_PRIME_EN
            primed_q <= primed_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign output_pulse = pulse_q;
    assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_linear_interpolator.sv
// Randomized bench for linear_interpolator against a queue-based model of the ramp outputs.
module tb_linear_interpolator;

    localparam int DW = 16;
`ifdef LINTERP_PRIME_EN
    localparam bit PRIME = 1'b1;
`else
    localparam bit PRIME = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic signed [DW-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic [2:0]           mode;
    logic signed [DW-1:0] dout;
    logic                 output_pulse;
    logic                 busy;

    linear_interpolator #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .mode         (mode),
        .dout         (dout),
        .output_pulse (output_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: outputs of the current segment still to be emitted, the last sample and last dout.
    int exp_q[$];
    int m_prev;
    int m_dout;
    bit m_primed;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int floor_div(input int a, input int r);
        int q;
        q = a / r;
        if ((a % r != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_prev   = 0;
        m_dout   = 0;
        m_primed = 1'b0;
    endtask

    // One clock: drive inputs, check din_ready, advance the model, check registered outputs.
    task automatic cycle(input bit en, input bit v, input int d, input int md);
        bit exp_ready;
        bit exp_pulse;
        int m;
        int r;
        int diff;
        enable    = en;
        din_valid = v;
        din       = d[DW-1:0];
        mode      = md[2:0];
        #1;
        exp_ready = en && (exp_q.size() == 0);
        check_val("din_ready", int'(din_ready), int'(exp_ready));
        exp_pulse = 1'b0;
        if (en) begin
            if (v && exp_ready) begin
                if (PRIME && !m_primed) begin
                    m_prev   = d;
                    m_primed = 1'b1;
                end else begin
                    m = (md > 4) ? 4 : md;
                    r = 1 << m;
                    diff = d - m_prev;
                    for (int k = 1; k <= r; k++) exp_q.push_back(floor_div(m_prev * r + diff * k, r));
                    m_prev   = d;
                    m_primed = 1'b1;
                end
            end
            if (exp_q.size() > 0) begin
                m_dout    = exp_q.pop_front();
                exp_pulse = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_val("output_pulse", int'(output_pulse), int'(exp_pulse));
        check_val("dout", int'(dout), m_dout);
        check_val("busy", int'(busy), int'(exp_q.size() > 0));
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_dout", int'(dout), 0);
        check_val("rst_pulse", int'(output_pulse), 0);
        check_val("rst_busy", int'(busy), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n, input int md);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, md);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; enable = 1'b0; din_valid = 1'b0; din = '0; mode = '0;
        #1;
        check_val("reset_dout", int'(dout), 0);
        check_val("reset_pulse", int'(output_pulse), 0);
        check_val("reset_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ramp to 8 at R=4, then 0 with valid held across the boundary.
        cycle(1, 1, 8, 2);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 2);
        idle_cycles(4, 2);

        // R=1 streaming.
        cycle(1, 1, 5, 0);
        cycle(1, 1, -7, 0);
        cycle(1, 1, 100, 0);
        idle_cycles(1, 0);

        // Floor rounding of negative values.
        mid_reset();
        cycle(1, 1, -3, 1);
        idle_cycles(2, 1);
        cycle(1, 1, 0, 1);
        idle_cycles(2, 1);

        // Full-scale swing at R=16.
        cycle(1, 1, -32768, 0);
        cycle(1, 1, -32768, 0);
        cycle(1, 1, 32767, 4);
        idle_cycles(17, 4);

        // Freeze with enable low and mode changed, then resume; next segment uses mode 6.
        cycle(1, 1, 1000, 3);
        idle_cycles(2, 3);
        for (int i = 0; i < 5; i++) cycle(0, 1, 77, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);
        cycle(1, 1, -500, 6);
        idle_cycles(17, 6);

        // Abandon a segment with reset.
        cycle(1, 1, 4000, 3);
        idle_cycles(3, 3);
        mid_reset();

        // First samples after reset (prime behaviour depends on build).
        cycle(1, 1, 10, 2);
        idle_cycles(1, 2);
        cycle(1, 1, 14, 2);
        idle_cycles(5, 2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int d;
            d = int'($urandom_range(0, 65535)) - 32768;
            if ($urandom_range(0, 599) == 0) mid_reset();
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, d, int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/linear_interpolator.md
Name: linear_interpolator

Overview:
Upsampling counterpart of the moving-average decimator. It accepts a low-rate signed sample stream over a valid/ready handshake and emits R = 2^mode linearly interpolated samples per input, one per enabled clock, ending exactly on the new input value. It sits on the reconstruction path, between a low-rate source and any consumer of dout/output_pulse.

Parameters:
DATA_WIDTH, 16, sample width in bits (signed two's complement)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  clock enable; low freezes all state
din  input  DATA_WIDTH  signed input sample
din_valid  input  1  din is valid
din_ready  output  1  block can accept din this cycle (combinational)
mode  input  3  ratio select: R = 1,2,4,8,16 for mode 0..4; values 5..7 behave as 4
dout  output  DATA_WIDTH  signed interpolated sample (registered)
output_pulse  output  1  dout updated this cycle (registered)
busy  output  1  segment in progress (state == RUN)

Behaviour:
- Reset: dout=0, output_pulse=0, busy=0, prev=0, diff=0, acc=0, cnt=0, state=IDLE. Reset mid-segment abandons the segment immediately.
- Accept condition: din_valid && din_ready. din_ready = enable && state==IDLE.
- States: IDLE and RUN. The block may only accept while IDLE.
- Let m = min(mode, 4). m is latched on accept as m_r. Mode changes mid-segment are ignored.
- On accept:
  - diff = din - prev, computed at DATA_WIDTH+1 bits (no overflow).
  - a0 = (prev <<< m) + diff, with acc width DATA_WIDTH+6 signed.
  - acc <= a0; dout <= a0 >>> m (arithmetic shift, floor).
  - output_pulse <= 1; prev <= din; cnt <= 1.
  - If R==1, stay in IDLE; otherwise go to RUN.
- In RUN, on each enabled cycle:
  - acc <= acc + diff; dout <= (acc + diff) >>> m_r; output_pulse <= 1; cnt++.
  - When the emitted output is the R-th (cnt == R-1 before increment), go to IDLE.
- Output k of a segment (k = 1..R) is floor((prev·R + diff·k) / R). Output R equals din exactly. All outputs lie between the old and new sample, so truncation to DATA_WIDTH never overflows.
- Latency: the first output_pulse occurs the cycle after accept. Pulses occupy R consecutive enabled cycles.
- Back-to-back: IDLE is re-entered on the edge that emits output R, so a valid held high is accepted on the next edge. The output stream is gapless, with one input per R cycles. Mode 0 sustains one input per cycle.
- IDLE with no accept: output_pulse <= 0; dout holds.
- enable low: no state changes, output_pulse <= 0, dout holds, din_ready = 0. Resuming continues the segment from the same cnt.
- busy = (state == RUN).

Optional Feature:
LINTERP_PRIME_EN
- Defined: the first accepted sample after reset only loads prev. No outputs are produced, state stays IDLE, and din_ready remains high. Interpolation starts from the second sample, which avoids a ramp up from 0.
- Undefined: the first segment ramps from prev=0.

Test Plan:
- Reset, mode=2, send 8 → dout 2,4,6,8 on 4 consecutive pulses; din_ready low for 3 cycles; then send 0 with valid held → 6,4,2,0 with no gap between segments.
- mode=0, stream 5,-7,100 with valid held continuously → din_ready always 1; dout 5,-7,100 on consecutive cycles.
- Rounding: reset, mode=1, send -3 → dout -2,-3; then send 0 → -2,0.
- Extremes: mode=4, prev=-32768, send 32767 → first dout -28673, 16th dout 32767, no wrap at any step.
- During a mode=3 segment, lower enable for 5 cycles and change mode to 0 → outputs and cnt freeze; on resume the remaining outputs follow the R=8 sequence; a mode value of 6 is treated as R=16.
- Assert rst_n mid-segment → dout=0, output_pulse=0, busy=0 immediately. With LINTERP_PRIME_EN: send 10, then 14 at mode=2 → no pulses for 10; then 11,12,13,14.
